// File: rtl/enc_dec_pkg.sv
// Shared types and helpers for the decoder result path.
// Error classification encoding and counter saturation check.
package enc_dec_pkg;

  typedef logic [1:0] num_errors_t;

  localparam num_errors_t NUM_ERR_NONE    = 2'b00;
  localparam num_errors_t NUM_ERR_SINGLE  = 2'b01;
  localparam num_errors_t NUM_ERR_DOUBLE  = 2'b10;
  localparam num_errors_t NUM_ERR_ILLEGAL = 2'b11;

  function automatic logic cnt_at_max(
    input logic [63:0] cnt,
    input int unsigned width
  );
    logic [63:0] max_v;
    if (width >= 64) max_v = '1;
    else max_v = (64'd1 << width) - 64'd1;
    return cnt == max_v;
  endfunction

endpackage

// File: rtl/dec_result_fifo.sv
// Generic synchronous FIFO with occupancy counter.
// Storage is reset so the head never reads as X.
module dec_result_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  fill_level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = fill_level == (AW+1)'(DEPTH);
  assign empty = fill_level == '0;
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally; full/empty come from fill_level only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
    end
  end

endmodule

// File: rtl/dec_result_buffer.sv
// Registered output stage behind the decoder output controller.
// Buffers results and keeps saturating error statistics.
module dec_result_buffer
  import enc_dec_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic [1:0]                  in_num_of_errors,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [1:0]                  out_num_of_errors,
  input  logic                        clr_counters,
  output logic [CNT_WIDTH-1:0]        cnt_single,
  output logic [CNT_WIDTH-1:0]        cnt_double,
  output logic                        sticky_double,
  output logic [$clog2(FIFO_DEPTH):0] fill_level
);

  localparam int PW = DATA_WIDTH + 2;

  logic          rdy_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [PW-1:0] rdata;
  num_errors_t   in_cls;

  // Held low until the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= 1'b0;
    else rdy_q <= 1'b1;
  end

  assign in_ready  = rdy_q & ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign in_cls    = in_num_of_errors;

  assign out_data          = rdata[DATA_WIDTH-1:0];
  assign out_num_of_errors = rdata[PW-1 -: 2];

  dec_result_fifo #(
    .W     (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .wdata      ({in_num_of_errors, in_data}),
    .rdata      (rdata),
    .full       (full),
    .empty      (empty),
    .fill_level (fill_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_single    <= '0;
      cnt_double    <= '0;
      sticky_double <= 1'b0;
    end else if (clr_counters) begin
      cnt_single    <= '0;
      cnt_double    <= '0;
      sticky_double <= 1'b0;
    end else if (push) begin
      unique case (1'b1)
        in_cls == NUM_ERR_SINGLE: begin
          if (!cnt_at_max(64'(cnt_single), CNT_WIDTH))
            cnt_single <= cnt_single + 1'b1;
        end
        in_cls == NUM_ERR_DOUBLE,
        in_cls == NUM_ERR_ILLEGAL: begin
          sticky_double <= 1'b1;
          if (!cnt_at_max(64'(cnt_double), CNT_WIDTH))
            cnt_double <= cnt_double + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_result_buffer.sv
// Scoreboard bench for dec_result_buffer.
// Directed steps drive stimulus; a negedge monitor checks outputs.
module tb_dec_result_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_num_of_errors;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_num_of_errors;
  logic          clr_counters;
  logic [CW-1:0] cnt_single;
  logic [CW-1:0] cnt_double;
  logic          sticky_double;
  logic [2:0]    fill_level;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW+1:0] sb[$];
  int            m_single;
  int            m_double;
  logic          m_sticky;
  logic          up;

  always #5 clk = ~clk;

  dec_result_buffer #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_num_of_errors  (in_num_of_errors),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_num_of_errors (out_num_of_errors),
    .clr_counters      (clr_counters),
    .cnt_single        (cnt_single),
    .cnt_double        (cnt_double),
    .sticky_double     (sticky_double),
    .fill_level        (fill_level)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) up <= 1'b0;
    else up <= 1'b1;
  end

  // Reference model: check state before the next edge, then advance
  always @(negedge clk) begin
    if (!rst) begin
      chk("fill", 64'(fill_level), 64'(sb.size()));
      chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      chk("in_ready", 64'(in_ready),
          64'(up && sb.size() != DEPTH));
      chk("cnt_single", 64'(cnt_single), 64'(m_single));
      chk("cnt_double", 64'(cnt_double), 64'(m_double));
      chk("sticky", 64'(sticky_double), 64'(m_sticky));
      if (out_valid && sb.size() != 0) begin
        chk("out_data", 64'(out_data), 64'(sb[0][DW-1:0]));
        chk("out_err", 64'(out_num_of_errors),
            64'(sb[0][DW+1:DW]));
      end
      if (out_valid && out_ready && sb.size() != 0)
        void'(sb.pop_front());
      if (clr_counters) begin
        m_single = 0;
        m_double = 0;
        m_sticky = 1'b0;
      end else if (in_valid && in_ready) begin
        if (in_num_of_errors == 2'b01) begin
          if (m_single < CMAX) m_single++;
        end else if (in_num_of_errors[1]) begin
          if (m_double < CMAX) m_double++;
          m_sticky = 1'b1;
        end
      end
      if (in_valid && in_ready)
        sb.push_back({in_num_of_errors, in_data});
    end
  end

  task automatic push_word(input logic [DW-1:0] d,
                           input logic [1:0] e);
    int n;
    in_valid = 1'b1;
    in_data = d;
    in_num_of_errors = e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("push_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 100 && sb.size() != 0; i++)
      @(posedge clk);
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_num_of_errors = 2'b00;
    out_ready = 1'b0;
    clr_counters = 1'b0;
    m_single = 0;
    m_double = 0;
    m_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_err", 64'(out_num_of_errors), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_cnt", 64'({cnt_single, cnt_double, sticky_double}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // single push, one-cycle latency
    push_word(32'hDEADBEEF, 2'b01);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data", 64'(out_data), 64'hDEADBEEF);
    chk("t1_err", 64'(out_num_of_errors), 64'd1);
    chk("t1_cnt", 64'(cnt_single), 64'd1);
    chk("t1_fill", 64'(fill_level), 64'd1);
    out_ready = 1'b1;
    wait_empty();
    out_ready = 1'b0;

    // fill to full, fifth word held back
    for (int i = 0; i < 4; i++)
      push_word(32'hA0 + 32'(i), 2'b00);
    chk("t2_fill", 64'(fill_level), 64'd4);
    chk("t2_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_data = 32'hA4;
    in_num_of_errors = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("t2_hold_fill", 64'(fill_level), 64'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++)
      @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_empty();
    out_ready = 1'b0;

    // streaming at fill level 2, pointers wrap
    push_word(32'hB0, 2'b00);
    push_word(32'hB1, 2'b00);
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'hC0 + 32'(i);
      @(posedge clk);
      #1;
      chk("t3_fill", 64'(fill_level), 64'd2);
    end
    in_valid = 1'b0;
    wait_empty();

    // classification mix, then clear colliding with a push
    clr_counters = 1'b1;
    @(posedge clk);
    #1;
    clr_counters = 1'b0;
    push_word(32'h100, 2'b00);
    push_word(32'h101, 2'b01);
    push_word(32'h102, 2'b10);
    push_word(32'h103, 2'b11);
    push_word(32'h104, 2'b01);
    chk("t4_single", 64'(cnt_single), 64'd2);
    chk("t4_double", 64'(cnt_double), 64'd2);
    chk("t4_sticky", 64'(sticky_double), 64'd1);
    clr_counters = 1'b1;
    push_word(32'h105, 2'b10);
    clr_counters = 1'b0;
    chk("t4_clr", 64'({cnt_single, cnt_double, sticky_double}), 64'd0);
    wait_empty();

    // saturation
    for (int i = 0; i < 20; i++)
      push_word(32'h200 + 32'(i), 2'b01);
    chk("t5_sat", 64'(cnt_single), 64'(CMAX));
    wait_empty();

    // asynchronous reset with entries buffered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push_word(32'h300 + 32'(i), 2'b10);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_fill", 64'(fill_level), 64'd0);
    chk("t6_cnt", 64'({cnt_single, cnt_double, sticky_double}), 64'd0);
    sb.delete();
    m_single = 0;
    m_double = 0;
    m_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    push_word(32'h77, 2'b10);
    chk("t6_first", 64'(m_double), 64'd1);
    wait_empty();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dec_result_buffer.md
Name: dec_result_buffer

Overview:
- Registered output stage directly downstream of the decoder output controller.
- Accepts corrected data plus the 2-bit error classification through a valid/ready handshake and buffers the results in a small FIFO.
- Presents buffered results to the consumer with valid/ready.
- Keeps saturating single- and double-error counters and a sticky double-error flag for status readout.

Parameters:
- DATA_WIDTH, 32, width of decoded data word.
- FIFO_DEPTH, 4, number of buffered entries; power of two, at least 2.
- CNT_WIDTH, 16, width of each error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  upstream result is valid.
- in_ready  output  1  buffer can accept this cycle.
- in_data  input  DATA_WIDTH  decoded data word.
- in_num_of_errors  input  2  error classification: 00 none, 01 single (corrected), 10 double (data zeroed), 11 illegal.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer accepts the head entry.
- out_data  output  DATA_WIDTH  head entry data.
- out_num_of_errors  output  2  head entry classification.
- clr_counters  input  1  synchronous clear of counters and sticky flag.
- cnt_single  output  CNT_WIDTH  accepted words classified 01.
- cnt_double  output  CNT_WIDTH  accepted words classified 10 or 11.
- sticky_double  output  1  set on any accepted 10/11 word; held until clr_counters.
- fill_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, active-high): pointers 0, fill_level 0, out_valid 0, out_data 0, out_num_of_errors 00, counters 0, sticky_double 0. in_ready goes 1 on the first clock after reset deasserts.
- Handshake terms:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (fill_level != FIFO_DEPTH). It does not depend on out_ready; there is no pass-through when full.
- Latency: an entry pushed at edge N is visible with out_valid=1 after edge N. There is no combinational bypass from in_* to out_*.
- Ordering: strict FIFO. out_data and out_num_of_errors come from storage at the read pointer and stay stable while out_valid & !out_ready.
- Storage states (an occupancy counter, not an explicit FSM):
  - EMPTY: fill_level 0, out_valid 0. Pop is impossible. Push goes to PARTIAL.
  - PARTIAL: 0 < fill_level < FIFO_DEPTH. Push only: fill_level +1. Pop only: fill_level -1. Push and pop together: fill_level unchanged, both pointers advance.
  - FULL: fill_level FIFO_DEPTH, in_ready 0. Pop goes to PARTIAL. Upstream data is not lost; upstream holds it.
- Pointers: log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH. Full/empty is decided by fill_level, not by pointer compare.
- When empty, out_data and out_num_of_errors are don't-care, but must not be X after reset (storage is reset to 0).
- Counters update on push only, by the classification of the pushed word:
  - 01 increments cnt_single.
  - 10 or 11 increments cnt_double and sets sticky_double.
  - 00 changes nothing.
- Counters saturate at 2^CNT_WIDTH-1; no wrap-around.
- clr_counters has priority: if it coincides with a push, the counters go to 0 and sticky_double to 0, and that word is not counted.
- clr_counters does not affect the FIFO contents or pointers.
- Reset mid-transfer discards all buffered entries; no partial output.

Decomposition:
- Shared package enc_dec_pkg:
  - typedef logic [1:0] num_errors_t.
  - Constants NUM_ERR_NONE=2'b00, NUM_ERR_SINGLE=2'b01, NUM_ERR_DOUBLE=2'b10, NUM_ERR_ILLEGAL=2'b11.
  - Function for counter-width saturation check.
- One sub-module: dec_result_fifo. A generic synchronous FIFO with DATA_WIDTH+2 payload, FIFO_DEPTH, the same clk/rst, push/pop/full/empty/fill_level.
- The top level adds the handshake mapping, the counters and the sticky flag.

Test Plan:
- Reset then single push: in_data=32'hDEADBEEF, in_num_of_errors=01, out_ready=0 -> next cycle out_valid=1, out_data=32'hDEADBEEF, out_num_of_errors=01, cnt_single=1, fill_level=1.
- Fill to full with out_ready=0: push 4 words A0..A3 -> fill_level=4, in_ready=0; a fifth word held on in_valid is not accepted. Set out_ready=1 -> A0..A3 emerge in order, then the held word.
- Simultaneous push/pop at fill_level=2 for 10 cycles -> fill_level stays 2, output order preserved, pointers wrap correctly.
- Classification mix 00,01,10,11,01 -> cnt_single=2, cnt_double=2, sticky_double=1. Pulse clr_counters on the same cycle as a push of 10 -> all counters 0, sticky_double 0.
- Saturation with CNT_WIDTH=4: push 20 words classified 01 -> cnt_single holds at 15.
- Assert rst with 3 entries buffered and out_ready=0 -> out_valid drops immediately, without waiting for a clock edge. fill_level=0, counters 0. After release the first new push is the first output.
